// File: rtl/bus_pkg.sv
// Shared defaults, arbiter state type and address helpers for the N-master/M-slave bus.
package bus_pkg;

  localparam int unsigned DEF_NUM_M    = 2;
  localparam int unsigned DEF_NUM_S    = 3;
  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_SEL_W    = 4;
  localparam int unsigned DEF_MAX_HOLD = 16;

  // Value driven onto the shared write strobe while nobody owns the bus.
  localparam logic IDLE_WR = 1'b0;

  typedef enum logic {StIdle, StOwn} arb_state_e;

  // Slave index held in the top sel_w bits of an addr_w-bit address.
  function automatic int unsigned sel_field(input logic [31:0] addr,
                                            input int unsigned addr_w,
                                            input int unsigned sel_w);
    return (addr >> (addr_w - sel_w)) & ((32'd1 << sel_w) - 32'd1);
  endfunction

endpackage

// File: rtl/bus_rr_nxm_if.sv
// Master-side and slave-side signal bundle of the shared bus; fabric is the bus's own view.
interface bus_rr_nxm_if #(
    parameter int unsigned NUM_M  = 2,
    parameter int unsigned NUM_S  = 3,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic [NUM_M-1:0]        m_req;
    logic [NUM_M-1:0]        m_wr;
    logic [NUM_M*ADDR_W-1:0] m_address;
    logic [NUM_M*DATA_W-1:0] m_dout;
    logic [NUM_M-1:0]        m_grant;
    logic [DATA_W-1:0]       m_din;
    logic                    m_rvalid;
    logic                    m_err;

    logic [NUM_S*DATA_W-1:0] s_dout;
    logic [NUM_S-1:0]        s_sel;
    logic [ADDR_W-1:0]       s_address;
    logic                    s_wr;
    logic [DATA_W-1:0]       s_din;

    modport master (
        output m_req, m_wr, m_address, m_dout,
        input  m_grant, m_din, m_rvalid, m_err
    );

    modport slave (
        input  s_sel, s_address, s_wr, s_din,
        output s_dout
    );

    modport fabric (
        input  m_req, m_wr, m_address, m_dout, s_dout,
        output m_grant, m_din, m_rvalid, m_err, s_sel, s_address, s_wr, s_din
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Registered round-robin arbiter with grant hold.
// Optional BUS_MAX_HOLD_EN limits ownership to MAX_HOLD cycles while others wait.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NUM_M    = DEF_NUM_M,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_M-1:0] req,
    output logic [NUM_M-1:0] grant
);
    localparam int unsigned IDX_W = $clog2(NUM_M);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_M - 1);

    arb_state_e       state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] next_idx;
    logic             found;
    logic             keep;
    int unsigned      cand;

`ifdef BUS_MAX_HOLD_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    logic [HOLD_W-1:0] hold_q;
    logic              preempt;
    assign preempt = (state_q == StOwn) && (hold_q == HOLD_MAX) && |(req & ~grant);
    assign keep    = (state_q == StOwn) && req[owner_q] && !preempt;
`else
    assign keep    = (state_q == StOwn) && req[owner_q];
`endif

    // Scan starts just past the last owner; the last owner itself is checked last.
    always_comb begin
        found    = 1'b0;
        next_idx = last_q;
        cand     = 0;
        for (int unsigned off = 1; off <= NUM_M; off++) begin
            cand = (32'(last_q) + off) % NUM_M;
            if (!found && req[IDX_W'(cand)]) begin
                found    = 1'b1;
                next_idx = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= LAST_RST;
            grant   <= '0;
`ifdef BUS_MAX_HOLD_EN
            hold_q  <= '0;
`endif
        end else if (keep) begin
`ifdef BUS_MAX_HOLD_EN
            if (hold_q != HOLD_MAX) hold_q <= hold_q + HOLD_W'(1);
`endif
        end else if (found) begin
            state_q <= StOwn;
            owner_q <= next_idx;
            last_q  <= next_idx;
            grant   <= NUM_M'(1) << next_idx;
`ifdef BUS_MAX_HOLD_EN
            hold_q  <= HOLD_W'(1);
`endif
        end else begin
            state_q <= StIdle;
            grant   <= '0;
`ifdef BUS_MAX_HOLD_EN
            hold_q  <= '0;
`endif
        end
    end
endmodule

// File: rtl/bus_rr_nxm.sv
// NUM_M-master / NUM_S-slave shared bus: round-robin owner, address decode, 1-cycle read return.
// Optional BUS_MAX_HOLD_EN bounds how long one master may keep the grant.
module bus_rr_nxm
    import bus_pkg::*;
#(
    parameter int unsigned NUM_M    = DEF_NUM_M,
    parameter int unsigned NUM_S    = DEF_NUM_S,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned SEL_W    = DEF_SEL_W,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input logic             clk,
    input logic             reset_n,
    bus_rr_nxm_if.fabric    bus
);
    localparam logic [SEL_W:0] NUM_S_EXT = (SEL_W + 1)'(NUM_S);

    logic [NUM_M-1:0]  grant;
    logic              any_grant;
    logic              wr;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  idx;
    logic              mapped;
    logic [NUM_S-1:0]  sel;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid_q;
    logic [SEL_W-1:0]  rd_idx_q;
    logic              err_q;

    bus_rr_arbiter #(
        .NUM_M    (NUM_M),
        .MAX_HOLD (MAX_HOLD)
    ) u_arbiter (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.m_req),
        .grant   (grant)
    );

    assign any_grant = |grant;

    // Grant is one-hot or zero, so an OR-mux yields zeros when the bus is idle.
    always_comb begin
        wr      = IDLE_WR;
        address = '0;
        wdata   = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (grant[i]) begin
                wr      = wr | bus.m_wr[i];
                address = address | bus.m_address[i*ADDR_W +: ADDR_W];
                wdata   = wdata | bus.m_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    assign idx    = SEL_W'(sel_field(32'(address), ADDR_W, SEL_W));
    assign mapped = {1'b0, idx} < NUM_S_EXT;

    always_comb begin
        sel = '0;
        for (int unsigned s = 0; s < NUM_S; s++) begin
            if (any_grant && mapped && idx == SEL_W'(s)) sel[s] = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned s = 0; s < NUM_S; s++) begin
            if (rd_valid_q && rd_idx_q == SEL_W'(s)) rdata = bus.s_dout[s*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= any_grant && !wr && mapped;
            rd_idx_q   <= idx;
            err_q      <= any_grant && !mapped;
        end
    end

    assign bus.m_grant   = grant;
    assign bus.m_din     = rdata;
    assign bus.m_rvalid  = rd_valid_q;
    assign bus.m_err     = err_q;
    assign bus.s_sel     = sel;
    assign bus.s_address = address;
    assign bus.s_wr      = wr;
    assign bus.s_din     = wdata;
endmodule
